// File: rtl/ps2_host_tx_if.sv
// Command-side port bundle of the PS/2 host transmitter.
// iSTART is a one-cycle request taken only while oBUSY=0 and no DONE/ERR pulse is showing;
// oDONE/oERR are mutually exclusive one-cycle completion pulses, and oBUSY is low during them.
interface ps2_host_tx_if;
  logic       iSTART;
  logic [7:0] iDATA;
  logic       oBUSY;
  logic       oDONE;
  logic       oERR;

  modport master (output iSTART, iDATA, input oBUSY, oDONE, oERR);
  modport slave  (input iSTART, iDATA, output oBUSY, oDONE, oERR);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one
// command byte (odd parity, stop) out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  ps2_host_tx_if.slave     cmd,
  input  logic             iPS2_CLK,
  input  logic             iPS2_DAT,
  output logic             oPS2_CLK_OE,
  output logic             oPS2_DAT_OE,
  output logic [2:0]       oDBG_STATE
);

  localparam int MAXC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    clk_sync_q, dat_sync_q;
  logic          clk_fall, clk_s, dat_s, timed_out;
  logic          clk_oe, dat_oe, busy, done, err;

  // [0],[1] form the synchroniser, [2] is the history flop; idle lines read high.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], iPS2_CLK};
      dat_sync_q <= {dat_sync_q[1:0], iPS2_DAT};
    end
  end

  assign clk_s     = clk_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign timed_out = (cnt_q == TO_LAST);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    clk_oe  = 1'b0;
    dat_oe  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd.iSTART) begin
          // Frame LSB first: start(0), data, odd parity, stop(1).
          frame_d = {1'b1, ~^cmd.iDATA, cmd.iDATA, 1'b0};
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        busy   = 1'b1;
        clk_oe = 1'b1;
        dat_oe = (cnt_q == INH_LAST);
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        busy   = 1'b1;
        dat_oe = ~frame_q[0];
        cnt_d  = cnt_q + 1'b1;
        if (timed_out) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          bit_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy   = 1'b1;
        dat_oe = ~frame_q[0];
        cnt_d  = cnt_q + 1'b1;
        if (timed_out) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          frame_d = {1'b1, frame_q[10:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timed_out)     state_d = S_ERR;
        else if (clk_fall) state_d = dat_s ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timed_out)          state_d = S_ERR;
        else if (clk_s && dat_s) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oPS2_CLK_OE = clk_oe;
  assign oPS2_DAT_OE = dat_oe;
  assign cmd.oBUSY   = busy;
  assign cmd.oDONE   = done;
  assign cmd.oERR    = err;
  assign oDBG_STATE  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device, frames checked
// against a bit-level model of the PS/2 host-to-device protocol.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TMO = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if cmd_if();
  logic       clk_oe, dat_oe, clk_pin, dat_pin;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic [2:0] dbg_state;

  assign clk_pin = ~(clk_oe | dev_clk_low);
  assign dat_pin = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .cmd         (cmd_if),
    .iPS2_CLK    (clk_pin),
    .iPS2_DAT    (dat_pin),
    .oPS2_CLK_OE (clk_oe),
    .oPS2_DAT_OE (dat_oe),
    .oDBG_STATE  (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_busy_cnt = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  always @(negedge clk) begin
    if (cmd_if.oDONE === 1'b1) done_cnt++;
    if (cmd_if.oERR === 1'b1) err_cnt++;
    if (cmd_if.oDONE === 1'b1 && cmd_if.oERR === 1'b1) both_cnt++;
    if ((cmd_if.oDONE === 1'b1 || cmd_if.oERR === 1'b1) && cmd_if.oBUSY !== 1'b0) pulse_busy_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_if.iSTART = 1'b1;
    cmd_if.iDATA  = b;
    @(negedge clk);
    cmd_if.iSTART = 1'b0;
    cmd_if.iDATA  = 8'($urandom);
  endtask

  // Device side: wait for request-to-send, clock max_bits bits sampling DAT on rising
  // edges, then (for a full frame) give the ACK clock with DAT low or high.
  task automatic dev_receive(input bit do_ack, input int max_bits, input int half, output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    got_q.delete();
    while (!(clk_pin === 1'b1 && dat_pin === 1'b0 && cmd_if.oBUSY === 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        ok = 1'b0;
        return;
      end
    end
    repeat (half) @(negedge clk);
    for (int i = 0; i < max_bits; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      got_q.push_back(dat_pin);
      dev_clk_low = 1'b0;
      repeat (half) @(negedge clk);
    end
    if (max_bits < 11) return;
    dev_dat_low = do_ack;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (half) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (cmd_if.oBUSY !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 4000) begin
        ok = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cmd_if.iSTART = 1'b0;
    cmd_if.iDATA  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmd_if.iSTART = 1'b1;
    @(negedge clk);
    cmd_if.iSTART = 1'b0;
    n_checks++; if (clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b expected 0", clk_oe); else n_pass++;
    n_checks++; if (dat_oe !== 1'b0) $display("FAIL reset_dat_oe: got %b expected 0", dat_oe); else n_pass++;
    n_checks++; if (cmd_if.oBUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cmd_if.oBUSY); else n_pass++;
    n_checks++; if (cmd_if.oDONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", cmd_if.oDONE); else n_pass++;
    n_checks++; if (cmd_if.oERR !== 1'b0) $display("FAIL reset_err: got %b expected 0", cmd_if.oERR); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_if.oBUSY !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", cmd_if.oBUSY); else n_pass++;
  endtask

  task automatic test_send_ack(input logic [7:0] b, input int half);
    bit ok, ok2;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    model_frame(b);
    send_cmd(b);
    dev_receive(1'b1, 11, half, ok);
    wait_idle(ok2);
    n_checks++; if (!ok || !ok2) $display("FAIL send_%h_wait: got dev=%0d idle=%0d expected 1/1", b, ok, ok2); else n_pass++;
    n_checks++; if (got_q.size() != 11) $display("FAIL send_%h_len: got %0d expected 11", b, got_q.size()); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      n_checks++; if (g !== e) $display("FAIL send_%h_bit%0d: got %b expected %b", b, i, g, e); else n_pass++;
    end
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL send_%h_done: got %0d expected 1", b, done_cnt - d0); else n_pass++;
    n_checks++; if (err_cnt - e0 != 0) $display("FAIL send_%h_err: got %0d expected 0", b, err_cnt - e0); else n_pass++;
  endtask

  task automatic test_inhibit();
    bit ok, ok2;
    int cnt, first, d0;
    d0 = done_cnt;
    send_cmd(8'($urandom));
    cnt = 0;
    first = 0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          if (clk_oe === 1'b1) begin
            cnt++;
            if (dat_oe === 1'b1 && first == 0) first = cnt;
          end else if (cnt > 0) begin
            break;
          end
          @(negedge clk);
        end
      end
      dev_receive(1'b1, 11, 18, ok);
    join
    wait_idle(ok2);
    n_checks++; if (cnt != INH) $display("FAIL inhibit_len: got %0d expected %0d", cnt, INH); else n_pass++;
    n_checks++; if (first != INH) $display("FAIL inhibit_dat_first: got %0d expected %0d", first, INH); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1 || !ok || !ok2) $display("FAIL inhibit_done: got %0d expected 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_nack();
    bit ok, ok2;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    model_frame(8'h01);
    send_cmd(8'h01);
    dev_receive(1'b0, 11, 20, ok);
    wait_idle(ok2);
    n_checks++; if (!ok || !ok2) $display("FAIL nack_wait: got dev=%0d idle=%0d expected 1/1", ok, ok2); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      n_checks++; if (g !== e) $display("FAIL nack_bit%0d: got %b expected %b", i, g, e); else n_pass++;
    end
    n_checks++; if (err_cnt - e0 != 1) $display("FAIL nack_err: got %0d expected 1", err_cnt - e0); else n_pass++;
    n_checks++; if (done_cnt - d0 != 0) $display("FAIL nack_done: got %0d expected 0", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int n, e0;
    e0 = err_cnt;
    send_cmd(8'($urandom));
    n = 0;
    while (clk_oe === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (cmd_if.oERR !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n != TMO) $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO); else n_pass++;
    n_checks++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) $display("FAIL timeout_release: got %b%b expected 00", clk_oe, dat_oe); else n_pass++;
    wait_idle(ok);
    n_checks++; if (err_cnt - e0 != 1 || !ok) $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    bit ok, ok2, busy_seen;
    int d0;
    d0 = done_cnt;
    model_frame(8'hFF);
    send_cmd(8'hFF);
    fork
      dev_receive(1'b1, 11, 20, ok);
      begin
        repeat (10) @(negedge clk);
        cmd_if.iSTART = 1'b1; cmd_if.iDATA = 8'h55;
        @(negedge clk);
        cmd_if.iSTART = 1'b0;
        repeat (150) @(negedge clk);
        cmd_if.iSTART = 1'b1; cmd_if.iDATA = 8'h55;
        @(negedge clk);
        cmd_if.iSTART = 1'b0;
      end
    join
    wait_idle(ok2);
    for (int i = 0; i < 11; i++) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      n_checks++; if (g !== e) $display("FAIL ignore_bit%0d: got %b expected %b", i, g, e); else n_pass++;
    end
    n_checks++; if (done_cnt - d0 != 1 || !ok || !ok2) $display("FAIL ignore_done: got %0d expected 1", done_cnt - d0); else n_pass++;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_if.oBUSY !== 1'b0) busy_seen = 1'b1;
    end
    n_checks++; if (busy_seen) $display("FAIL ignore_no_requeue: got busy=1 expected 0"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int n, d0;
    logic [7:0] b1, b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    d0 = done_cnt;
    send_cmd(b1);
    dev_receive(1'b1, 11, 16, ok);
    n = 0;
    while (cmd_if.oDONE !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (cmd_if.oDONE !== 1'b1 || !ok) $display("FAIL b2b_first_done: got %b expected 1", cmd_if.oDONE); else n_pass++;
    cmd_if.iSTART = 1'b1;
    cmd_if.iDATA  = b2;
    @(negedge clk);
    n_checks++; if (cmd_if.oBUSY !== 1'b0) $display("FAIL b2b_start_on_pulse: got busy=%b expected 0", cmd_if.oBUSY); else n_pass++;
    @(negedge clk);
    cmd_if.iSTART = 1'b0;
    n_checks++; if (cmd_if.oBUSY !== 1'b1) $display("FAIL b2b_start_next_idle: got busy=%b expected 1", cmd_if.oBUSY); else n_pass++;
    model_frame(b2);
    dev_receive(1'b1, 11, 16, ok);
    wait_idle(ok2);
    for (int i = 0; i < 11; i++) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      n_checks++; if (g !== e) $display("FAIL b2b_%h_bit%0d: got %b expected %b", b2, i, g, e); else n_pass++;
    end
    n_checks++; if (done_cnt - d0 != 2 || !ok || !ok2) $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0, e0;
    logic [7:0] b;
    b  = 8'hF4;
    d0 = done_cnt;
    e0 = err_cnt;
    model_frame(b);
    send_cmd(b);
    dev_receive(1'b1, 5, 20, ok);
    for (int i = 0; i < 5; i++) begin
      logic [0:0] e, g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      n_checks++; if (g !== e || !ok) $display("FAIL rstmid_bit%0d: got %b expected %b", i, g, e); else n_pass++;
    end
    n_checks++; if (dat_oe !== ~b[3]) $display("FAIL rstmid_drive_b3: got %b expected %b", dat_oe, ~b[3]); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) $display("FAIL rstmid_release: got %b%b expected 00", clk_oe, dat_oe); else n_pass++;
    n_checks++; if (cmd_if.oBUSY !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", cmd_if.oBUSY); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (done_cnt != d0 || err_cnt != e0) $display("FAIL rstmid_no_pulse: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); else n_pass++;
    test_send_ack(8'hF4, 20);
  endtask

  task automatic test_pulse_rules();
    n_checks++; if (both_cnt != 0) $display("FAIL pulse_exclusive: got %0d expected 0", both_cnt); else n_pass++;
    n_checks++; if (pulse_busy_cnt != 0) $display("FAIL pulse_busy_low: got %0d expected 0", pulse_busy_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_send_ack(8'hED, 25);
    test_inhibit();
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_back_to_back();
    for (int r = 0; r < 3; r++) test_send_ack(8'($urandom), int'($urandom_range(15, 25)));
    test_reset_mid();
    test_pulse_rules();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
